// File: rtl/rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// rx_link_ctrl
//
// Link bring-up and frame supervisor for a DPHY/CSI-style receive path.
// Sequences DPHY power-down, waits for byte-clock PLL lock, holds the receiver
// in reset for a fixed time, then synchronises to the first VSS short packet.
// While locked it counts active-video long packets per frame, flags word-count
// and line-count mismatches, and keeps a saturating error total. Three events
// trigger recovery: watchdog expiry, PLL lock loss, or a run of consecutive bad
// frames.
//
// Build option:
//   RX_LINK_AUTO_RECOVER_EN  defined   : recovery re-runs the power-up sequence
//                            undefined : recovery parks in FAULT until reset_i
//
// Ports:
//   clk_byte_fr_i  in   1  sole clock; all outputs registered on it
//   reset_i        in   1  synchronous reset, active-high
//   pll_lock_i     in   1  byte-clock PLL lock
//   sp_en_i        in   1  short-packet strobe
//   dt_i           in   6  data type, valid with sp_en_i (6'h01 = VSS)
//   lp_av_en_i     in   1  active-video long-packet strobe
//   wc_i           in  16  word count, valid with lp_av_en_i
//   pd_dphy_o      out  1  DPHY power-down
//   rx_reset_n_o   out  1  receiver/B2P reset, active-low
//   link_up_o      out  1  high while LOCKED
//   frame_start_o  out  1  one-cycle pulse per accepted VSS
//   wc_err_o       out  1  one-cycle pulse on word-count mismatch
//   frame_err_o    out  1  one-cycle pulse on line-count mismatch
//   line_cnt_o     out 12  packets seen in the current frame
//   err_cnt_o      out  8  total errors (saturating)
//   state_o        out  3  state encoding
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rx_link_ctrl #(
  parameter logic [15:0] PD_CYCLES  = 16'd1024,
  parameter logic [15:0] RST_CYCLES = 16'd16,
  parameter logic [15:0] EXP_WC     = 16'd3840,
  parameter logic [11:0] EXP_LINES  = 12'd1024,
  parameter logic [23:0] WDT_CYCLES = 24'd4000000,
  parameter logic [2:0]  ERR_LIMIT  = 3'd4
) (
  input  logic        clk_byte_fr_i,
  input  logic        reset_i,
  input  logic        pll_lock_i,
  input  logic        sp_en_i,
  input  logic [5:0]  dt_i,
  input  logic        lp_av_en_i,
  input  logic [15:0] wc_i,
  output logic        pd_dphy_o,
  output logic        rx_reset_n_o,
  output logic        link_up_o,
  output logic        frame_start_o,
  output logic        wc_err_o,
  output logic        frame_err_o,
  output logic [11:0] line_cnt_o,
  output logic [7:0]  err_cnt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_LOCK = 3'd1,
    RST_HOLD  = 3'd2,
    WAIT_VSS  = 3'd3,
    LOCKED    = 3'd4,
    FAULT     = 3'd5
  } state_t;

`ifdef RX_LINK_AUTO_RECOVER_EN
  localparam state_t REC_STATE = PWRDN;
`else
  localparam state_t REC_STATE = FAULT;
`endif

  localparam logic [5:0] DT_VSS = 6'h01;

  // Saturating helpers for the frame/error counters.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [15:0] phase_cnt;
  logic [23:0] wdt_cnt;
  logic [2:0]  bad_cnt;
  logic [11:0] line_cnt;
  logic [7:0]  err_cnt;

  logic       vss;
  logic       in_link;
  logic       vss_acc;
  logic       activity;
  logic       wdt_on;
  logic       wdt_hit;
  logic       pd_done;
  logic       rst_done;
  logic       pll_lost;
  logic       frame_bad;
  logic       wc_bad;
  logic [3:0] bad_inc;
  logic       bad_limit;
  logic       rec_event;
  logic [1:0] err_inc;

  always_comb begin
    vss      = sp_en_i && (dt_i == DT_VSS);
    in_link  = (state == WAIT_VSS) || (state == LOCKED);
    vss_acc  = in_link && vss;
    // Any packet traffic proves the link is alive once the receiver runs.
    activity = in_link && (sp_en_i || lp_av_en_i);
    wdt_on   = (state == WAIT_LOCK) || in_link;
    // Fires on the cycle the count would reach WDT_CYCLES, so the state
    // change lands exactly WDT_CYCLES edges after the last clear.
    wdt_hit  = wdt_on && !activity &&
               (({1'b0, wdt_cnt} + 25'd1) >= {1'b0, WDT_CYCLES});
    pd_done  = ({1'b0, phase_cnt} + 17'd1) >= {1'b0, PD_CYCLES};
    rst_done = ({1'b0, phase_cnt} + 17'd1) >= {1'b0, RST_CYCLES};
    pll_lost = !pll_lock_i && ((state == RST_HOLD) || in_link);

    // Frame check uses the count before any same-cycle packet is added.
    frame_bad = (state == LOCKED) && vss && (line_cnt != EXP_LINES);
    // A packet coincident with an accepted VSS belongs to the new frame and
    // is still word-count checked.
    wc_bad    = lp_av_en_i && ((state == LOCKED) || vss_acc) && (wc_i != EXP_WC);
    bad_inc   = {1'b0, bad_cnt} + 4'd1;
    bad_limit = frame_bad && (bad_inc >= {1'b0, ERR_LIMIT});
    rec_event = wdt_hit || pll_lost || bad_limit;
    err_inc   = {1'b0, wc_bad} + {1'b0, frame_bad};

    state_nxt = state;
    if (rec_event) begin
      state_nxt = REC_STATE;
    end else begin
      case (state)
        PWRDN:     if (pd_done)    state_nxt = WAIT_LOCK;
        WAIT_LOCK: if (pll_lock_i) state_nxt = RST_HOLD;
        RST_HOLD:  if (rst_done)   state_nxt = WAIT_VSS;
        WAIT_VSS:  if (vss)        state_nxt = LOCKED;
        LOCKED:                    state_nxt = LOCKED;
        FAULT:                     state_nxt = FAULT;
        default:                   state_nxt = PWRDN;
      endcase
    end
  end

  always_ff @(posedge clk_byte_fr_i) begin
    if (reset_i) begin
      state         <= PWRDN;
      phase_cnt     <= '0;
      wdt_cnt       <= '0;
      bad_cnt       <= '0;
      line_cnt      <= '0;
      err_cnt       <= '0;
      pd_dphy_o     <= 1'b1;
      rx_reset_n_o  <= 1'b0;
      link_up_o     <= 1'b0;
      frame_start_o <= 1'b0;
      wc_err_o      <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Level outputs are decoded from the next state so they switch on the
      // same edge as state_o.
      pd_dphy_o    <= (state_nxt == PWRDN) || (state_nxt == FAULT);
      rx_reset_n_o <= (state_nxt == WAIT_VSS) || (state_nxt == LOCKED);
      link_up_o    <= (state_nxt == LOCKED);

      frame_start_o <= vss_acc;
      wc_err_o      <= wc_bad;
      frame_err_o   <= frame_bad;
      err_cnt       <= sat_add8(err_cnt, err_inc);

      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if ((state == PWRDN) || (state == RST_HOLD)) begin
        phase_cnt <= phase_cnt + 16'd1;
      end

      if ((state_nxt != state) || activity) begin
        wdt_cnt <= '0;
      end else if (wdt_on) begin
        wdt_cnt <= wdt_cnt + 24'd1;
      end

      if (rec_event) begin
        line_cnt <= '0;
        bad_cnt  <= '0;
      end else begin
        if (vss_acc) begin
          line_cnt <= lp_av_en_i ? 12'd1 : 12'd0;
        end else if ((state == LOCKED) && lp_av_en_i) begin
          line_cnt <= sat_inc12(line_cnt);
        end

        if (frame_bad) begin
          bad_cnt <= bad_inc[2:0];
        end else if ((state == LOCKED) && vss) begin
          bad_cnt <= '0;
        end
      end
    end
  end

  assign line_cnt_o = line_cnt;
  assign err_cnt_o  = err_cnt;
  assign state_o    = state;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_link_ctrl
//
// Self-checking bench for rx_link_ctrl. Strobe traffic goes through drv(),
// which updates a small frame model and queues the expected pulses, line
// count, error count and link state; a monitor pops one entry per clock and
// compares. Power-up timing, watchdog, PLL loss and reset are checked inline.
// Expected recovery state follows RX_LINK_AUTO_RECOVER_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rx_link_ctrl;

`ifdef RX_LINK_AUTO_RECOVER_EN
  localparam logic [2:0] REC_ST = 3'd0;
`else
  localparam logic [2:0] REC_ST = 3'd5;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        pll_lock_i = 1'b1;
  logic        sp_en_i = 1'b0;
  logic [5:0]  dt_i = 6'd0;
  logic        lp_av_en_i = 1'b0;
  logic [15:0] wc_i = 16'd0;
  logic        pd_dphy_o;
  logic        rx_reset_n_o;
  logic        link_up_o;
  logic        frame_start_o;
  logic        wc_err_o;
  logic        frame_err_o;
  logic [11:0] line_cnt_o;
  logic [7:0]  err_cnt_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  rx_link_ctrl #(
    .PD_CYCLES  (16'd8),
    .RST_CYCLES (16'd4),
    .WDT_CYCLES (24'd100)
  ) dut (
    .clk_byte_fr_i (clk),
    .reset_i       (reset_i),
    .pll_lock_i    (pll_lock_i),
    .sp_en_i       (sp_en_i),
    .dt_i          (dt_i),
    .lp_av_en_i    (lp_av_en_i),
    .wc_i          (wc_i),
    .pd_dphy_o     (pd_dphy_o),
    .rx_reset_n_o  (rx_reset_n_o),
    .link_up_o     (link_up_o),
    .frame_start_o (frame_start_o),
    .wc_err_o      (wc_err_o),
    .frame_err_o   (frame_err_o),
    .line_cnt_o    (line_cnt_o),
    .err_cnt_o     (err_cnt_o),
    .state_o       (state_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        fs;
    logic        wce;
    logic        fe;
    logic        lk;
    logic [11:0] line;
    logic [7:0]  errc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Frame model state
  int m_line = 0;
  int m_err  = 0;
  int m_bad  = 0;
  bit m_lk   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("frame_start", frame_start_o, mon_e.fs);
      chk("wc_err",      wc_err_o,      mon_e.wce);
      chk("frame_err",   frame_err_o,   mon_e.fe);
      chk("link_up",     link_up_o,     mon_e.lk);
      chk("line_cnt",    line_cnt_o,    mon_e.line);
      chk("err_cnt",     err_cnt_o,     mon_e.errc);
    end
  end

  // One clock of strobe stimulus plus its expected outcome.
  task automatic drv(input logic vss, input logic sp_nv, input logic lp, input logic [15:0] wc);
    exp_t e;
    @(negedge clk);
    sp_en_i    = vss | sp_nv;
    dt_i       = vss ? 6'h01 : 6'h02;
    lp_av_en_i = lp;
    wc_i       = wc;
    e.fs  = vss;
    e.wce = lp && (m_lk || vss) && (wc != 16'd3840);
    e.fe  = vss && m_lk && (m_line != 1024);
    if (vss) begin
      if (m_lk) m_bad = e.fe ? m_bad + 1 : 0;
      m_line = lp ? 1 : 0;
      m_lk   = 1'b1;
    end else if (lp && m_lk && m_line < 4095) begin
      m_line++;
    end
    m_err = m_err + int'(e.wce) + int'(e.fe);
    if (m_err > 255) m_err = 255;
    if (m_bad >= 4) begin
      m_lk   = 1'b0;
      m_line = 0;
      m_bad  = 0;
    end
    e.lk   = m_lk;
    e.line = 12'(m_line);
    e.errc = 8'(m_err);
    sb_q.push_back(e);
  endtask

  task automatic pkts(input int n, input logic [15:0] wc);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b1, wc);
  endtask

  task automatic quiet();
    @(negedge clk);
    sp_en_i    = 1'b0;
    lp_av_en_i = 1'b0;
    dt_i       = 6'd0;
    wc_i       = 16'd0;
  endtask

  task automatic reset_powerup();
    int t_pd;
    int t_rst;
    logic [2:0] st9;
    @(negedge clk);
    reset_i = 1'b1; pll_lock_i = 1'b1;
    sp_en_i = 1'b0; dt_i = 6'd0; lp_av_en_i = 1'b0; wc_i = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",  state_o, 3'd0);
    chk("rst_pd",     pd_dphy_o, 1'b1);
    chk("rst_rstn",   rx_reset_n_o, 1'b0);
    chk("rst_link",   link_up_o, 1'b0);
    chk("rst_pulses", {frame_start_o, wc_err_o, frame_err_o}, 3'd0);
    chk("rst_line",   line_cnt_o, 12'd0);
    chk("rst_err",    err_cnt_o, 8'd0);
    @(negedge clk);
    reset_i = 1'b0;
    t_pd = 0; t_rst = 0; st9 = 3'd7;
    for (int i = 1; i <= 60 && t_rst == 0; i++) begin
      @(posedge clk);
      #1;
      if (t_pd == 0 && pd_dphy_o == 1'b0) t_pd = i;
      if (t_rst == 0 && rx_reset_n_o == 1'b1) t_rst = i;
      if (i == 9) st9 = state_o;
    end
    chk("pd_fall_cyc",   t_pd, 8);
    chk("rst_hold_st",   st9, 3'd2);
    chk("rstn_rise_cyc", t_rst, 13);
    chk("wait_vss_st",   state_o, 3'd3);
    chk("wait_vss_link", link_up_o, 1'b0);
    m_line = 0; m_err = 0; m_bad = 0; m_lk = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL global_timeout n_vec=%0d", n_vec);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Power-up timing and first good frame
    reset_powerup();
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    pkts(1024, 16'd3840);
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    chk("good_frame_err", err_cnt_o, 8'd0);

    // One bad word count in a 1023-packet frame
    pkts(100, 16'd3840);
    drv(1'b0, 1'b0, 1'b1, 16'd3837);
    pkts(922, 16'd3840);
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    chk("short_frame_err", err_cnt_o, 8'd2);

    // VSS with coincident packet: pre-increment frame check, line loads 1
    pkts(1024, 16'd3840);
    drv(1'b1, 1'b0, 1'b1, 16'd3837);
    @(posedge clk); #1;
    chk("vss_lp_line", line_cnt_o, 12'd1);
    chk("vss_lp_err",  err_cnt_o, 8'd3);
    pkts(1023, 16'd3840);
    drv(1'b1, 1'b0, 1'b0, 16'd0);

    // Simultaneous wc and frame errors add two
    pkts(10, 16'd3840);
    drv(1'b1, 1'b0, 1'b1, 16'd1);
    @(posedge clk); #1;
    chk("dual_err", err_cnt_o, 8'd5);

    // Line counter saturation
    pkts(4200, 16'd3840);
    @(posedge clk); #1;
    chk("line_sat", line_cnt_o, 12'd4095);
    drv(1'b1, 1'b0, 1'b0, 16'd0);

    // Good frame with a non-VSS short packet in the middle
    pkts(500, 16'd3840);
    drv(1'b0, 1'b1, 1'b0, 16'd0);
    pkts(524, 16'd3840);
    drv(1'b1, 1'b0, 1'b0, 16'd0);

    // Watchdog expiry in LOCKED, counted from the last VSS
    @(posedge clk);
    quiet();
    repeat (99) @(posedge clk);
    #1;
    chk("wdt_99_state", state_o, 3'd4);
    chk("wdt_99_link",  link_up_o, 1'b1);
    @(posedge clk); #1;
    chk("wdt_100_state", state_o, REC_ST);
    chk("wdt_100_link",  link_up_o, 1'b0);
    chk("wdt_100_line",  line_cnt_o, 12'd0);
    chk("wdt_100_err",   err_cnt_o, 8'd6);

    // Error-count saturation and consecutive bad-frame recovery
    reset_powerup();
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    pkts(260, 16'd3837);
    drv(1'b1, 1'b0, 1'b1, 16'd3837);
    @(posedge clk); #1;
    chk("err_sat", err_cnt_o, 8'd255);
    for (int f = 0; f < 2; f++) begin
      pkts(5, 16'd3840);
      drv(1'b1, 1'b0, 1'b0, 16'd0);
    end
    pkts(5, 16'd3840);
    @(posedge clk); #1;
    chk("pre_limit_link", link_up_o, 1'b1);
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    chk("limit_state", state_o, REC_ST);
    chk("limit_link",  link_up_o, 1'b0);
    chk("limit_line",  line_cnt_o, 12'd0);
    chk("limit_err",   err_cnt_o, 8'd255);

    // PLL lock loss for one cycle
    reset_powerup();
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    pkts(20, 16'd3840);
    @(negedge clk);
    chk("pre_pll_link", link_up_o, 1'b1);
    sp_en_i = 1'b0; lp_av_en_i = 1'b0; pll_lock_i = 1'b0;
    @(negedge clk);
    pll_lock_i = 1'b1;
    chk("pll_link",  link_up_o, 1'b0);
    chk("pll_state", state_o, REC_ST);
    chk("pll_line",  line_cnt_o, 12'd0);

    // Mid-frame reset
    reset_powerup();
    drv(1'b1, 1'b0, 1'b0, 16'd0);
    pkts(30, 16'd3840);
    drv(1'b0, 1'b0, 1'b1, 16'd100);
    @(posedge clk); #1;
    chk("mid_err",  err_cnt_o, 8'd1);
    chk("mid_line", line_cnt_o, 12'd31);
    reset_powerup();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
